// File: rtl/matrix_stream_feeder.sv
// matrix_stream_feeder
// Holds NUM_MAT matrices of ELEMS elements in a local buffer. It feeds them to
// the compute core one matrix at a time. Each matrix gets a core_start pulse
// and is then sent as a valid/ready element stream. The feeder waits for
// core_finish before it starts the next matrix.
// Optional build macro: FEEDER_LOOP_EN. When it is defined, a start seen in
// DONE launches the next run at once, with no IDLE cycle in between.

module matrix_stream_feeder #(
    parameter int DATA_W  = 7,
    parameter int ELEMS   = 32,
    parameter int NUM_MAT = 2,
    localparam int ADDR_W = $clog2(ELEMS * NUM_MAT),
    localparam int MIDX_W = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              abort,
    output logic              core_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              core_finish,
    output logic [MIDX_W-1:0] mat_idx,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);

    localparam int TOTAL = ELEMS * NUM_MAT;
    localparam int CNT_W = $clog2(ELEMS);

    localparam logic [ADDR_W:0]   TOTAL_W   = (ADDR_W + 1)'(TOTAL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0]  LAST_ELEM = CNT_W'(ELEMS - 1);
    localparam logic [MIDX_W-1:0] LAST_MAT  = MIDX_W'(NUM_MAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT_FIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] mem [TOTAL];

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [CNT_W-1:0]  elem_cnt;

    logic handshake;
    logic last_elem;
    logic last_mat;
    logic wr_in_range;
    logic wr_accept;

    assign handshake   = out_valid & out_ready;
    assign last_elem   = (elem_cnt == LAST_ELEM);
    assign last_mat    = (mat_idx == LAST_MAT);
    assign addr_inc    = addr + 1'b1;
    assign wr_in_range = ({1'b0, wr_addr} < TOTAL_W);
    assign wr_accept   = wr_en & ~busy & wr_in_range;

    // Host-side buffer write port. The buffer is deliberately kept through reset and abort.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Flag a write that was refused because a run was active or the address was outside the buffer.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en & (busy | ~wr_in_range);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. An abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (handshake && last_elem) begin
                    state_nxt = S_WAIT_FIN;
                end
            end
            S_WAIT_FIN: begin
                if (core_finish) begin
                    state_nxt = last_mat ? S_DONE : S_START;
                end
            end
            S_DONE: begin
`ifdef FEEDER_LOOP_EN
                state_nxt = start ? S_START : S_IDLE;
`else
                state_nxt = S_IDLE;
`endif
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Control outputs, decoded directly from the current state.
    always_comb begin
        core_start = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE:     busy       = 1'b0;
            S_START:    core_start = 1'b1;
            S_STREAM:   out_valid  = 1'b1;
            S_WAIT_FIN: ;
            S_DONE:     done       = 1'b1;
            default:    busy       = 1'b0;
        endcase
    end

    // Datapath: read address, element counter, matrix index and the registered element.
    // The next element is fetched at the same edge that accepts the current one.
    // This lets the stream run at one element per cycle.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            addr     <= '0;
            elem_cnt <= '0;
            mat_idx  <= '0;
            out_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr    <= '0;
                        mat_idx <= '0;
                    end
                end
                S_START: begin
                    out_data <= mem[addr];
                    elem_cnt <= '0;
                end
                S_STREAM: begin
                    if (handshake) begin
                        elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
                        if (addr != LAST_ADDR) begin
                            addr     <= addr_inc;
                            out_data <= mem[addr_inc];
                        end
                    end
                end
                S_WAIT_FIN: begin
                    if (core_finish && !last_mat) begin
                        mat_idx <= mat_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    mat_idx <= '0;
`ifdef FEEDER_LOOP_EN
                    if (start) begin
                        addr <= '0;
                    end
`endif
                end
                default: begin
                    addr     <= '0;
                    elem_cnt <= '0;
                    mat_idx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_feeder.sv
// tb_matrix_stream_feeder
// Directed bench for matrix_stream_feeder. When a run is started, its expected elements go into a queue.
// The negedge monitor pops one entry per accepted element and compares it.
// If FEEDER_LOOP_EN is defined, the back-to-back restart case is also checked.

module tb_matrix_stream_feeder;

    localparam int DATA_W  = 7;
    localparam int ELEMS   = 32;
    localparam int NUM_MAT = 2;
    localparam int TOTAL   = ELEMS * NUM_MAT;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [5:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              abort;
    logic              core_start;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              core_finish;
    logic [0:0]        mat_idx;
    logic              busy;
    logic              done;
    logic              wr_err;

    int checks     = 0;
    int errors     = 0;
    int hs_count   = 0;
    int cs_count   = 0;
    int done_count = 0;

    logic [15:0]       exp_q[$];
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    matrix_stream_feeder #(
        .DATA_W  (DATA_W),
        .ELEMS   (ELEMS),
        .NUM_MAT (NUM_MAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .abort       (abort),
        .core_start  (core_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .core_finish (core_finish),
        .mat_idx     (mat_idx),
        .busy        (busy),
        .done        (done),
        .wr_err      (wr_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write one buffer entry through the host port.
    task automatic apply_stimulus(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 6'(a);
        wr_data = 7'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    // Queue the expected elements {matrix, data} for buffer addresses first..last-1.
    task automatic push_run(input int first, input int last);
        for (int a = first; a < last; a++) begin
            exp_q.push_back(16'(((a / ELEMS) << 8) | a));
        end
    endtask

    // Wait until the monitor has seen target handshakes, optionally toggling out_ready.
    task automatic wait_hs(input int target, input bit toggle, input int budget);
        int n;
        n = 0;
        while (hs_count < target && n < budget) begin
            if (toggle) out_ready = ~out_ready;
            tick();
            n++;
        end
        checks++;
        assert (hs_count >= target)
        else begin
            errors++;
            $error("FAIL hs_timeout: observed %0d handshakes expected %0d", hs_count, target);
        end
    endtask

    // Pulse start and confirm the start-to-core_start and start-to-first-valid latency.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("lat_core_start", 32'(core_start), 32'd1);
        check_output("lat_busy", 32'(busy), 32'd1);
        check_output("lat_no_valid_yet", 32'(out_valid), 32'd0);
        tick();
        check_output("lat_first_valid", 32'(out_valid), 32'd1);
        check_output("lat_first_data", 32'(out_data), 32'd0);
        check_output("lat_start_gone", 32'(core_start), 32'd0);
    endtask

    // The core finishes 3 cycles after the last element. Then check the next start or the done pulse.
    task automatic finish_matrix(input bit last);
        repeat (3) tick();
        check_output("wait_fin_busy", 32'(busy), 32'd1);
        check_output("wait_fin_no_valid", 32'(out_valid), 32'd0);
        core_finish = 1'b1;
        tick();
        core_finish = 1'b0;
        if (last) begin
            check_output("done_pulse", 32'(done), 32'd1);
            check_output("done_mat_idx", 32'(mat_idx), 32'd1);
            check_output("done_busy", 32'(busy), 32'd1);
            tick();
            check_output("done_cleared", 32'(done), 32'd0);
            check_output("idle_busy", 32'(busy), 32'd0);
            check_output("idle_mat_idx", 32'(mat_idx), 32'd0);
        end else begin
            check_output("next_core_start", 32'(core_start), 32'd1);
            check_output("next_mat_idx", 32'(mat_idx), 32'd1);
        end
    endtask

    // A complete two-matrix run, either with ready held high or with ready toggling.
    task automatic run_full(input bit toggle);
        int base;
        int cs0;
        int d0;
        base = hs_count;
        cs0  = cs_count;
        d0   = done_count;
        out_ready = 1'b1;
        push_run(0, TOTAL);
        pulse_start();
        wait_hs(base + ELEMS, toggle, 400);
        finish_matrix(1'b0);
        wait_hs(base + TOTAL, toggle, 400);
        finish_matrix(1'b1);
        out_ready = 1'b1;
        check_output("run_core_starts", 32'(cs_count - cs0), 32'd2);
        check_output("run_done_pulses", 32'(done_count - d0), 32'd1);
        check_output("run_handshakes", 32'(hs_count - base), 32'(TOTAL));
        check_output("run_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: counts pulses, checks that the element is held while stalled, and scores each accepted element.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst && !abort) begin
            if (core_start) cs_count++;
            if (done) done_count++;
            if (out_valid && prev_valid && !prev_ready) begin
                check_output("hold_stable", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                hs_count++;
                checks++;
                assert (exp_q.size() > 0)
                else begin
                    errors++;
                    $error("FAIL unexpected_hs: observed data 0x%0h expected no element", out_data);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_output("elem_data", 32'(out_data), 32'(e[6:0]));
                    check_output("elem_mat", 32'(mat_idx), 32'(e[15:8]));
                end
            end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
    end

    // Directed sequence.
    initial begin
        int base;
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        start       = 1'b0;
        abort       = 1'b0;
        out_ready   = 1'b1;
        core_finish = 1'b0;
        tick();
        tick();
        check_output("rst_core_start", 32'(core_start), 32'd0);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_data", 32'(out_data), 32'd0);
        check_output("rst_mat_idx", 32'(mat_idx), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_wr_err", 32'(wr_err), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] loading buffer");
        for (int i = 0; i < TOTAL; i++) begin
            apply_stimulus(i, i);
        end
        check_output("load_no_wr_err", 32'(wr_err), 32'd0);

        $display("[TB] full run, ready held high");
        run_full(1'b0);

        $display("[TB] full run, ready toggling");
        run_full(1'b1);

        $display("[TB] rejected write and ignored finishes");
        base = hs_count;
        push_run(0, TOTAL);
        pulse_start();
        wait_hs(base + 2, 1'b0, 100);
        apply_stimulus(5, 7'h7F);
        check_output("wr_err_pulse", 32'(wr_err), 32'd1);
        tick();
        check_output("wr_err_single", 32'(wr_err), 32'd0);
        wait_hs(base + 10, 1'b0, 100);
        core_finish = 1'b1;
        tick();
        core_finish = 1'b0;
        check_output("finish_in_stream_ignored", 32'(out_valid), 32'd1);
        wait_hs(base + ELEMS - 1, 1'b0, 100);
        core_finish = 1'b1;
        tick();
        core_finish = 1'b0;
        check_output("last_hs_count", 32'(hs_count - base), 32'(ELEMS));
        check_output("last_hs_valid_drop", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_output("still_wait_fin_busy", 32'(busy), 32'd1);
            check_output("still_wait_fin_no_start", 32'(core_start), 32'd0);
            tick();
        end
        finish_matrix(1'b0);
        wait_hs(base + TOTAL, 1'b0, 200);
        finish_matrix(1'b1);
        check_output("wr_run_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] abort on element 10 of matrix 1");
        base = hs_count;
        push_run(0, ELEMS + 10);
        pulse_start();
        wait_hs(base + ELEMS, 1'b0, 200);
        finish_matrix(1'b0);
        wait_hs(base + ELEMS + 10, 1'b0, 200);
        check_output("abort_elem_presented", 32'(out_data), 32'(ELEMS + 10));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("abort_out_valid", 32'(out_valid), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_mat_idx", 32'(mat_idx), 32'd0);
        check_output("abort_out_data", 32'(out_data), 32'd0);
        check_output("abort_handshakes", 32'(hs_count - base), 32'(ELEMS + 10));
        check_output("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();

        $display("[TB] replay after abort");
        run_full(1'b0);

        $display("[TB] start held through DONE");
        base = hs_count;
        push_run(0, TOTAL);
        pulse_start();
        wait_hs(base + ELEMS, 1'b0, 200);
        finish_matrix(1'b0);
        wait_hs(base + TOTAL, 1'b0, 200);
        repeat (3) tick();
        start       = 1'b1;
        core_finish = 1'b1;
        tick();
        core_finish = 1'b0;
        check_output("hold_start_done", 32'(done), 32'd1);
        tick();
`ifdef FEEDER_LOOP_EN
        check_output("loop_core_start", 32'(core_start), 32'd1);
        check_output("loop_busy", 32'(busy), 32'd1);
        check_output("loop_mat_idx", 32'(mat_idx), 32'd0);
`else
        check_output("noloop_idle_gap", 32'(busy), 32'd0);
        check_output("noloop_no_start", 32'(core_start), 32'd0);
        tick();
        check_output("noloop_restart", 32'(core_start), 32'd1);
`endif
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("final_abort_busy", 32'(busy), 32'd0);
        check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
